// File: rtl/cache_req_queue.sv
// Cache request stage: buffers trace commands in a DEPTH-entry FIFO and issues them one at a time to the cache.
// Optional CACHE_REQ_STATS_EN adds saturating retired-read/retired-write counters.
module cache_req_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_op,
    input  logic                     in_write,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_wdata,
    output logic                     cache_valid,
    input  logic                     cache_ready,
    output logic [OPW-1:0]           cache_op,
    output logic [AW-1:0]            cache_addr,
    output logic [DW-1:0]            cache_wdata,
    output logic                     cache_data_oe,
    input  logic [DW-1:0]            cache_rdata,
    output logic                     resp_valid,
    output logic [DW-1:0]            resp_data,
    output logic [$clog2(DEPTH):0]   count
`ifdef CACHE_REQ_STATS_EN
    ,
    output logic [31:0]              stat_reads,
    output logic [31:0]              stat_writes
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [OPW-1:0] mem_op    [DEPTH];
    logic           mem_write [DEPTH];
    logic [AW-1:0]  mem_addr  [DEPTH];
    logic [DW-1:0]  mem_wdata [DEPTH];

    state_t         state_q;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q;
    logic           cache_valid_q, cache_data_oe_q, cur_write_q;
    logic [OPW-1:0] cache_op_q;
    logic [AW-1:0]  cache_addr_q;
    logic [DW-1:0]  cache_wdata_q;
    logic           resp_valid_q;
    logic [DW-1:0]  resp_data_q;
    logic           full, push, pop;

    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == IDLE) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wptr_q]    <= in_op;
            mem_write[wptr_q] <= in_write;
            mem_addr[wptr_q]  <= in_addr;
            mem_wdata[wptr_q] <= in_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            cache_valid_q   <= 1'b0;
            cache_data_oe_q <= 1'b0;
            cur_write_q     <= 1'b0;
            cache_op_q      <= '0;
            cache_addr_q    <= '0;
            cache_wdata_q   <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cache_op_q      <= mem_op[rptr_q];
                        cache_addr_q    <= mem_addr[rptr_q];
                        cache_wdata_q   <= mem_wdata[rptr_q];
                        cache_data_oe_q <= mem_write[rptr_q];
                        cur_write_q     <= mem_write[rptr_q];
                        cache_valid_q   <= 1'b1;
                        rptr_q          <= rptr_q + 1'b1;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_ready) begin
                        cache_valid_q   <= 1'b0;
                        cache_data_oe_q <= 1'b0;
                        resp_valid_q    <= 1'b1;
                        resp_data_q     <= cur_write_q ? '0 : cache_rdata;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_REQ_STATS_EN
    logic [31:0] stat_reads_q, stat_writes_q;
    logic        retire;

    assign retire = (state_q == ISSUE) && cache_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else if (retire) begin
            if (cur_write_q) begin
                if (stat_writes_q != '1) stat_writes_q <= stat_writes_q + 1'b1;
            end else begin
                if (stat_reads_q != '1) stat_reads_q <= stat_reads_q + 1'b1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

    assign cache_valid   = cache_valid_q;
    assign cache_op      = cache_op_q;
    assign cache_addr    = cache_addr_q;
    assign cache_wdata   = cache_wdata_q;
    assign cache_data_oe = cache_data_oe_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign count         = count_q;

endmodule

// File: tb/tb_cache_req_queue.sv
// Directed bench for cache_req_queue: vector table of single transactions plus multi-cycle corner sequences.
module tb_cache_req_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 8;
    localparam int unsigned OPW   = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, in_write;
    logic [OPW-1:0] in_op;
    logic [AW-1:0]  in_addr;
    logic [DW-1:0]  in_wdata;
    logic           cache_valid, cache_ready, cache_data_oe;
    logic [OPW-1:0] cache_op;
    logic [AW-1:0]  cache_addr;
    logic [DW-1:0]  cache_wdata, cache_rdata;
    logic           resp_valid;
    logic [DW-1:0]  resp_data;
    logic [3:0]     count;
`ifdef CACHE_REQ_STATS_EN
    logic [31:0]    stat_reads, stat_writes;
`endif

    cache_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_write(in_write),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .cache_valid(cache_valid), .cache_ready(cache_ready), .cache_op(cache_op),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_data_oe(cache_data_oe),
        .cache_rdata(cache_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .count(count)
`ifdef CACHE_REQ_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic           write;
        logic [OPW-1:0] op;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  rdata;
        int unsigned    delay;
        logic [DW-1:0]  exp_resp;
        logic           exp_oe;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int unsigned idx);
        in_valid = 1'b1; in_write = v.write; in_op = v.op; in_addr = v.addr; in_wdata = v.wdata;
        tick();
        in_valid = 1'b0;
        chk($sformatf("v%0d_count_after_push", idx), 64'(count), 64'd1);
        chk($sformatf("v%0d_valid_not_yet", idx), 64'(cache_valid), 64'd0);
        tick();
        chk($sformatf("v%0d_valid", idx), 64'(cache_valid), 64'd1);
        chk($sformatf("v%0d_addr", idx), 64'(cache_addr), 64'(v.addr));
        chk($sformatf("v%0d_op", idx), 64'(cache_op), 64'(v.op));
        chk($sformatf("v%0d_oe", idx), 64'(cache_data_oe), 64'(v.exp_oe));
        if (v.write) chk($sformatf("v%0d_wdata", idx), 64'(cache_wdata), 64'(v.wdata));
        for (int unsigned i = 0; i < v.delay; i++) begin
            tick();
            chk($sformatf("v%0d_hold_valid", idx), 64'(cache_valid), 64'd1);
            chk($sformatf("v%0d_hold_addr", idx), 64'(cache_addr), 64'(v.addr));
            chk($sformatf("v%0d_hold_oe", idx), 64'(cache_data_oe), 64'(v.exp_oe));
            chk($sformatf("v%0d_no_early_resp", idx), 64'(resp_valid), 64'd0);
        end
        cache_ready = 1'b1; cache_rdata = v.rdata;
        tick();
        cache_ready = 1'b0; cache_rdata = 8'h5A;
        chk($sformatf("v%0d_valid_clear", idx), 64'(cache_valid), 64'd0);
        chk($sformatf("v%0d_oe_clear", idx), 64'(cache_data_oe), 64'd0);
        chk($sformatf("v%0d_resp_valid", idx), 64'(resp_valid), 64'd1);
        chk($sformatf("v%0d_resp_data", idx), 64'(resp_data), 64'(v.exp_resp));
        tick();
        chk($sformatf("v%0d_resp_pulse", idx), 64'(resp_valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{write:1'b0, op:4'h1, addr:32'h0000_1000, wdata:8'h00, rdata:8'hA5, delay:2, exp_resp:8'hA5, exp_oe:1'b0};
        vecs[1] = '{write:1'b1, op:4'h2, addr:32'h0000_0020, wdata:8'h3C, rdata:8'h77, delay:0, exp_resp:8'h00, exp_oe:1'b1};
        vecs[2] = '{write:1'b0, op:4'hF, addr:32'hFFFF_FFFF, wdata:8'h99, rdata:8'hFF, delay:1, exp_resp:8'hFF, exp_oe:1'b0};
        vecs[3] = '{write:1'b1, op:4'h0, addr:32'h0000_0000, wdata:8'hFF, rdata:8'h11, delay:3, exp_resp:8'h00, exp_oe:1'b1};
        vecs[4] = '{write:1'b0, op:4'h7, addr:32'h1234_5678, wdata:8'h00, rdata:8'h00, delay:0, exp_resp:8'h00, exp_oe:1'b0};

        reset = 1'b1; in_valid = 1'b0; in_write = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
        cache_ready = 1'b0; cache_rdata = '0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(cache_valid), 64'd0);
        chk("rst_oe", 64'(cache_data_oe), 64'd0);
        chk("rst_addr", 64'(cache_addr), 64'd0);
        chk("rst_resp", 64'(resp_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // cache_ready while idle must not retire anything
        cache_ready = 1'b1; cache_rdata = 8'hEE;
        tick();
        cache_ready = 1'b0;
        chk("idle_ready_ignored", 64'(resp_valid), 64'd0);
        chk("idle_ready_resp_data", 64'(resp_data), 64'd0);

        for (int unsigned k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Back-to-back with cache_ready held high: one bubble cycle between commands
        in_valid = 1'b1; in_write = 1'b0; in_op = 4'h3; in_addr = 32'hA0;
        tick();
        chk("b2b_count1", 64'(count), 64'd1);
        in_addr = 32'hB0;
        tick();
        in_valid = 1'b0;
        chk("b2b_pushpop_count", 64'(count), 64'd1);
        chk("b2b_validA", 64'(cache_valid), 64'd1);
        chk("b2b_addrA", 64'(cache_addr), 64'hA0);
        cache_ready = 1'b1; cache_rdata = 8'h42;
        tick();
        chk("b2b_retireA", 64'(resp_valid), 64'd1);
        chk("b2b_bubble", 64'(cache_valid), 64'd0);
        chk("b2b_dataA", 64'(resp_data), 64'h42);
        tick();
        chk("b2b_validB", 64'(cache_valid), 64'd1);
        chk("b2b_addrB", 64'(cache_addr), 64'hB0);
        chk("b2b_resp_low", 64'(resp_valid), 64'd0);
        chk("b2b_count0", 64'(count), 64'd0);
        tick();
        chk("b2b_retireB", 64'(resp_valid), 64'd1);
        cache_ready = 1'b0;
        tick();
        chk("b2b_resp_pulse", 64'(resp_valid), 64'd0);

        // Fill: first command issues, eight more fill the FIFO
        for (int unsigned i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_write = 1'b0; in_op = 4'(i); in_addr = 32'(i);
            tick();
        end
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_head_addr", 64'(cache_addr), 64'd0);
        in_addr = 32'hDEAD;
        tick();
        chk("fill_push_ignored", 64'(count), 64'd8);
        cache_ready = 1'b1; cache_rdata = 8'h80;
        tick();
        cache_ready = 1'b0;
        chk("fill_retire0", 64'(resp_valid), 64'd1);
        chk("fill_retire0_data", 64'(resp_data), 64'h80);
        chk("fill_still_full", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("full_pushpop_count", 64'(count), 64'd7);
        chk("full_pushpop_ready", 64'(in_ready), 64'd1);
        for (int unsigned k = 1; k < 9; k++) begin
            chk($sformatf("order_valid%0d", k), 64'(cache_valid), 64'd1);
            chk($sformatf("order_addr%0d", k), 64'(cache_addr), 64'(k));
            cache_ready = 1'b1; cache_rdata = 8'(k);
            tick();
            cache_ready = 1'b0;
            chk($sformatf("order_resp%0d", k), 64'(resp_data), 64'(k));
            tick();
        end
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_idle", 64'(cache_valid), 64'd0);

        // Reset during ISSUE with three entries queued
        for (int unsigned i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_write = 1'b1; in_op = 4'h9; in_addr = 32'h100 + 32'(i); in_wdata = 8'hC3;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd3);
        chk("pre_rst_oe", 64'(cache_data_oe), 64'd1);
        #2;
        reset = 1'b1; cache_ready = 1'b1;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(cache_valid), 64'd0);
        chk("midrst_oe", 64'(cache_data_oe), 64'd0);
        chk("midrst_addr", 64'(cache_addr), 64'd0);
        chk("midrst_wdata", 64'(cache_wdata), 64'd0);
        tick();
        reset = 1'b0; cache_ready = 1'b0;
        tick();
        chk("postrst_resp", 64'(resp_valid), 64'd0);
        chk("postrst_valid", 64'(cache_valid), 64'd0);
        chk("postrst_ready", 64'(in_ready), 64'd1);

`ifdef CACHE_REQ_STATS_EN
        chk("stat_rst_reads", 64'(stat_reads), 64'd0);
        chk("stat_rst_writes", 64'(stat_writes), 64'd0);
        for (int unsigned k = 0; k < 8; k++) run_vec(vecs[(k < 5) ? ((k % 2) * 2) : 1], 10 + k);
        chk("stat_reads", 64'(stat_reads), 64'd5);
        chk("stat_writes", 64'(stat_writes), 64'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
